// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: next-PC sequencer for the dual-issue fetch path.
// Selects trap / execute / decode / sequential next PC, keeps the fetch PC
// 8-byte aligned with per-slot valids, and squashes in-flight wrong-path pairs
// for FLUSH_CYCLES unstalled cycles after any accepted redirect.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0008,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        trap_redirect_i,
  input  logic [31:0] trap_target_i,
  input  logic        ex_redirect_i,
  input  logic [31:0] ex_target_i,
  input  logic        id_redirect_i,
  input  logic [31:0] id_target_i,
  output logic [31:0] pc_o,
  output logic        slot0_valid_o,
  output logic        slot1_valid_o,
  output logic [1:0]  pc_mux_o,
  output logic        flush_o
);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      state, state_nx;
  logic [2:0]  flush_cnt, flush_cnt_nx;
  logic [31:0] pc_nx;
  logic        slot0_nx, slot1_nx;
  logic [31:0] target;
  logic        redirect;
  logic        unused_target_bits;

  // Word offset bits of the target never reach the pair-aligned PC.
  assign unused_target_bits = ^target[1:0];

  // Flush indication comes straight from the state flop.
  assign flush_o = (state == FLUSH);

  // Redirect source select: trap > ex > id; id is wrong-path while flushing.
  always_comb begin
    pc_mux_o = 2'd0;
    target   = '0;
    if (trap_redirect_i) begin
      pc_mux_o = 2'd3;
      target   = trap_target_i;
    end else if (ex_redirect_i) begin
      pc_mux_o = 2'd2;
      target   = ex_target_i;
    end else if (id_redirect_i && (state != FLUSH)) begin
      pc_mux_o = 2'd1;
      target   = id_target_i;
    end
    redirect = (pc_mux_o != 2'd0);
  end

  // Next PC, slot valids, flush state and counter.
  always_comb begin
    state_nx     = state;
    flush_cnt_nx = flush_cnt;
    pc_nx        = pc_o;
    slot0_nx     = slot0_valid_o;
    slot1_nx     = slot1_valid_o;
    if (redirect) begin
      pc_nx        = {target[31:3], 3'b000};
      slot0_nx     = ~target[2];
      slot1_nx     = 1'b1;
      state_nx     = FLUSH;
      flush_cnt_nx = FLUSH_LOAD;
    end else if (!stall_i) begin
      pc_nx    = pc_o + 32'd8;
      slot0_nx = 1'b1;
      slot1_nx = 1'b1;
      if (state == FLUSH) begin
        // Leaving on the edge that would bring the count to zero keeps
        // flush_o high for exactly FLUSH_CYCLES unstalled cycles.
        if (flush_cnt <= 3'd1) begin
          state_nx     = RUN;
          flush_cnt_nx = '0;
        end else begin
          flush_cnt_nx = flush_cnt - 3'd1;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= RUN;
      flush_cnt     <= '0;
      pc_o          <= RESET_PC;
      slot0_valid_o <= 1'b1;
      slot1_valid_o <= 1'b1;
    end else begin
      state         <= state_nx;
      flush_cnt     <= flush_cnt_nx;
      pc_o          <= pc_nx;
      slot0_valid_o <= slot0_nx;
      slot1_valid_o <= slot1_nx;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios plus random
// traffic, all checked against a behavioural next-PC model.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0008;
  localparam int          FC     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        trap = 1'b0, ex = 1'b0, id = 1'b0;
  logic [31:0] trap_t = '0, ex_t = '0, id_t = '0;
  logic [31:0] pc;
  logic        v0, v1, flush;
  logic [1:0]  mux;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [31:0] m_pc = RST_PC;
  logic        m_v0 = 1'b1, m_v1 = 1'b1;
  int          m_left = 0;      // flush cycles still owed
  logic [1:0]  mux_obs, mux_exp;

  fetch_pc_ctrl #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FC)) dut (
    .clock_i(clk), .reset_i(rst), .stall_i(stall),
    .trap_redirect_i(trap), .trap_target_i(trap_t),
    .ex_redirect_i(ex), .ex_target_i(ex_t),
    .id_redirect_i(id), .id_target_i(id_t),
    .pc_o(pc), .slot0_valid_o(v0), .slot1_valid_o(v1),
    .pc_mux_o(mux), .flush_o(flush)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RST_PC; m_v0 = 1'b1; m_v1 = 1'b1; m_left = 0;
  endtask

  // Apply one cycle of inputs, record the combinational source select,
  // take the clock edge and advance the model. Returns at posedge+1.
  task automatic drive(input logic s, input logic tr, input logic [31:0] tt,
                       input logic e, input logic [31:0] et,
                       input logic i, input logic [31:0] it);
    logic [31:0] tgt;
    stall = s; trap = tr; trap_t = tt; ex = e; ex_t = et; id = i; id_t = it;
    #2;
    mux_obs = mux;
    if (tr)                   begin mux_exp = 2'd3; tgt = tt; end
    else if (e)               begin mux_exp = 2'd2; tgt = et; end
    else if (i && m_left == 0) begin mux_exp = 2'd1; tgt = it; end
    else                      begin mux_exp = 2'd0; tgt = '0; end
    @(posedge clk);
    if (mux_exp != 2'd0) begin
      m_pc = tgt & 32'hFFFF_FFF8; m_v0 = ~tgt[2]; m_v1 = 1'b1; m_left = FC;
    end else if (!s) begin
      m_pc = m_pc + 32'd8; m_v0 = 1'b1; m_v1 = 1'b1;
      if (m_left > 0) m_left = m_left - 1;
    end
    #1;
    stall = 1'b0; trap = 1'b0; ex = 1'b0; id = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vectors++; if (pc !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
    vectors++; if ({v0, v1} !== 2'b11) begin errors++; $display("FAIL reset_valid: got %b want 11", {v0, v1}); end
    vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush); end
    vectors++; if (mux !== 2'd0) begin errors++; $display("FAIL reset_mux: got %0d want 0", mux); end
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    // that edge advanced from RESET_PC
    m_pc = m_pc + 32'd8;
  endtask

  task automatic test_sequential();
    logic [31:0] base;
    base = pc;
    vectors++; if (base !== 32'h10) begin errors++; $display("FAIL seq_start: got %h want 10", base); end
    for (int k = 1; k <= 4; k++) begin
      idle();
      vectors++; if (pc !== base + 32'(8 * k)) begin errors++; $display("FAIL seq_pc: got %h want %h", pc, base + 32'(8 * k)); end
      vectors++; if ({v0, v1, flush, mux_obs} !== 5'b11000) begin errors++; $display("FAIL seq_ctl: got %b want 11000", {v0, v1, flush, mux_obs}); end
    end
  endtask

  task automatic test_ex_redirect();
    drive(1'b0, 1'b0, '0, 1'b1, 32'h104, 1'b0, '0);
    vectors++; if (mux_obs !== 2'd2) begin errors++; $display("FAIL ex_mux: got %0d want 2", mux_obs); end
    vectors++; if (pc !== 32'h100) begin errors++; $display("FAIL ex_pc: got %h want 100", pc); end
    vectors++; if ({v0, v1, flush} !== 3'b011) begin errors++; $display("FAIL ex_ctl: got %b want 011", {v0, v1, flush}); end
    idle();
    vectors++; if ({pc, v0, v1, flush} !== {32'h108, 3'b111}) begin errors++; $display("FAIL ex_f2: got %h %b want 108 111", pc, {v0, v1, flush}); end
    idle();
    vectors++; if ({pc, flush} !== {32'h110, 1'b0}) begin errors++; $display("FAIL ex_end: got %h %b want 110 0", pc, flush); end
  endtask

  task automatic test_priority();
    drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h400);
    vectors++; if (mux_obs !== 2'd3) begin errors++; $display("FAIL prio_mux: got %0d want 3", mux_obs); end
    vectors++; if (pc !== 32'h200) begin errors++; $display("FAIL prio_pc: got %h want 200", pc); end
    idle(); idle();
    vectors++; if ({pc, flush} !== {32'h210, 1'b0}) begin errors++; $display("FAIL prio_drop: got %h %b want 210 0", pc, flush); end
  endtask

  task automatic test_id_ignored();
    drive(1'b0, 1'b0, '0, 1'b1, 32'h600, 1'b0, '0);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h500);
    vectors++; if ({mux_obs, pc} !== {2'd0, 32'h608}) begin errors++; $display("FAIL id_ign1: got %0d %h want 0 608", mux_obs, pc); end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h500);
    vectors++; if ({mux_obs, pc, flush} !== {2'd0, 32'h610, 1'b0}) begin errors++; $display("FAIL id_ign2: got %0d %h %b want 0 610 0", mux_obs, pc, flush); end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h500);
    vectors++; if ({mux_obs, pc, flush} !== {2'd1, 32'h500, 1'b1}) begin errors++; $display("FAIL id_take: got %0d %h %b want 1 500 1", mux_obs, pc, flush); end
    idle(); idle();
  endtask

  task automatic test_stall_in_flush();
    drive(1'b0, 1'b0, '0, 1'b1, 32'h700, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      vectors++; if ({mux_obs, pc, flush} !== {2'd0, 32'h700, 1'b1}) begin errors++; $display("FAIL stall_hold: got %0d %h %b want 0 700 1", mux_obs, pc, flush); end
    end
    idle();
    vectors++; if ({pc, flush} !== {32'h708, 1'b1}) begin errors++; $display("FAIL stall_f1: got %h %b want 708 1", pc, flush); end
    idle();
    vectors++; if ({pc, flush} !== {32'h710, 1'b0}) begin errors++; $display("FAIL stall_f2: got %h %b want 710 0", pc, flush); end
  endtask

  task automatic test_wrap_and_reset();
    drive(1'b0, 1'b1, 32'hFFFF_FFEC, 1'b0, '0, 1'b0, '0);
    vectors++; if ({pc, v0} !== {32'hFFFF_FFE8, 1'b0}) begin errors++; $display("FAIL wrap_tgt: got %h %b want ffffffe8 0", pc, v0); end
    idle(); idle();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    vectors++; if ({pc, v0, v1} !== {32'hFFFF_FFF8, 2'b11}) begin errors++; $display("FAIL wrap_hold: got %h %b want fffffff8 11", pc, {v0, v1}); end
    idle();
    vectors++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want 0", pc); end
    drive(1'b0, 1'b0, '0, 1'b1, 32'h800, 1'b0, '0);
    rst = 1'b1;
    #1;
    vectors++; if ({pc, flush, v0, v1} !== {RST_PC, 3'b011}) begin errors++; $display("FAIL async_rst: got %h %b want %h 011", pc, {flush, v0, v1}, RST_PC); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle();
    vectors++; if ({pc, flush} !== {RST_PC + 32'd8, 1'b0}) begin errors++; $display("FAIL post_rst: got %h %b want %h 0", pc, flush, RST_PC + 32'd8); end
  endtask

  task automatic test_random();
    logic s, tr, e, i;
    for (int n = 0; n < 400; n++) begin
      s  = ($urandom_range(3) == 0);
      tr = ($urandom_range(15) == 0);
      e  = ($urandom_range(7) == 0);
      i  = ($urandom_range(4) == 0);
      drive(s, tr, $urandom, e, $urandom, i, $urandom);
      vectors++; if (mux_obs !== mux_exp) begin errors++; $display("FAIL rnd_mux[%0d]: got %0d want %0d", n, mux_obs, mux_exp); end
      vectors++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, pc, m_pc); end
      vectors++; if ({v0, v1} !== {m_v0, m_v1}) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, {v0, v1}, {m_v0, m_v1}); end
      vectors++; if (flush !== (m_left > 0)) begin errors++; $display("FAIL rnd_flush[%0d]: got %b want %b", n, flush, (m_left > 0)); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ex_redirect();
    test_priority();
    test_id_ignored();
    test_stall_in_flush();
    test_wrap_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
